// File: rtl/ram_arbiter.sv
// Two-master front end for the byte-lane RAM: shares the single read port between
// fetch (m0) and load/store (m1), and routes the registered read data back to its owner.
module ram_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_be,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_ren,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } own_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    own_e       rsp_own_q, rsp_own_d;

    logic m1_store, m1_load, hazard, force_m0;

    assign m1_store = m1_req & m1_we;
    assign m1_load  = m1_req & ~m1_we;
    // Only the word index matters for read-during-write; byte offset is the requester's concern.
    assign hazard   = m1_store & m0_req & (m0_addr[AW-1:2] == m1_addr[AW-1:2]);
    assign force_m0 = (starve_q == STARVE_LIM);

    always_comb begin
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        ram_ren    = 1'b0;
        ram_r_addr = '0;
        ram_wen    = 4'b0000;
        ram_w_addr = '0;
        ram_w_data = '0;
        starve_d   = 4'd0;
        rsp_own_d  = OWN_NONE;

        if (rstn) begin
            m1_gnt = m1_store | (m1_load & ~(m0_req & force_m0));
            m0_gnt = m0_req & ~hazard & (~m1_load | force_m0);

            if (m1_gnt && m1_we) begin
                ram_wen    = m1_be;
                ram_w_addr = m1_addr;
                ram_w_data = m1_wdata;
            end

            if (m0_gnt) begin
                ram_ren    = 1'b1;
                ram_r_addr = m0_addr;
                rsp_own_d  = OWN_M0;
            end else if (m1_gnt && !m1_we) begin
                ram_ren    = 1'b1;
                ram_r_addr = m1_addr;
                rsp_own_d  = OWN_M1;
            end

            // Denied fetch cycles (contention or hazard stall) age m0, saturating at the limit.
            if (m0_req && !m0_gnt) begin
                starve_d = force_m0 ? starve_q : starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_q  <= 4'd0;
            rsp_own_q <= OWN_NONE;
        end else begin
            starve_q  <= starve_d;
            rsp_own_q <= rsp_own_d;
        end
    end

    // Gating with rstn drops a response whose grant landed just before reset.
    assign m0_rvalid = rstn & (rsp_own_q == OWN_M0);
    assign m1_rvalid = rstn & (rsp_own_q == OWN_M1);
    assign m0_rdata  = m0_rvalid ? ram_r_data : '0;
    assign m1_rdata  = m1_rvalid ? ram_r_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small byte-lane RAM model whose words
// are preloaded with 0xDA7A0000 | word_index.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [3:0]  ram_wen;
    logic [31:0] ram_w_addr, ram_w_data;
    logic        ram_ren;
    logic [31:0] ram_r_addr;
    logic [31:0] ram_r_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    ram_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wen(ram_wen), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_ren(ram_ren), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    // RAM model: registered read, byte-lane writes, read sees the pre-write word.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDA7A_0000 | 32'(i);
        ram_r_data = 32'h0;
        forever begin
            @(posedge clk);
            if (ram_ren) ram_r_data <= mem[ram_r_addr[11:2]];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_w_addr[11:2]][8*b +: 8] <= ram_w_data[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_addr = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with both masters requesting
        idle();
        rstn = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_addr = 32'h104;
        #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_ren", 32'(ram_ren), 32'd0);
        chk("rst_wen", 32'(ram_wen), 32'd0);
        next_cycle();
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        next_cycle();

        // First fetch after reset
        rstn = 1'b1;
        idle();
        m0_req = 1'b1; m0_addr = 32'h100;
        #1;
        chk("fetch_gnt", 32'(m0_gnt), 32'd1);
        chk("fetch_ren", 32'(ram_ren), 32'd1);
        chk("fetch_raddr", ram_r_addr, 32'h100);
        next_cycle();
        chk("fetch_rvalid", 32'(m0_rvalid), 32'd1);
        chk("fetch_rdata", m0_rdata, 32'hDA7A_0040);
        chk("fetch_m1_rvalid", 32'(m1_rvalid), 32'd0);

        // Continuous contention: m1 x4, m0 x1, repeating
        m0_req = 1'b1; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("cont_m0_gnt_%0d", k), 32'(m0_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("cont_m1_gnt_%0d", k), 32'(m1_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
            next_cycle();
            if (k % 5 == 4) begin
                chk($sformatf("cont_m0_rv_%0d", k), 32'(m0_rvalid), 32'd1);
                chk($sformatf("cont_m1_rv_%0d", k), 32'(m1_rvalid), 32'd0);
                chk($sformatf("cont_m0_rd_%0d", k), m0_rdata, 32'hDA7A_0004);
            end else begin
                chk($sformatf("cont_m0_rv_%0d", k), 32'(m0_rvalid), 32'd0);
                chk($sformatf("cont_m1_rv_%0d", k), 32'(m1_rvalid), 32'd1);
                chk($sformatf("cont_m1_rd_%0d", k), m1_rdata, 32'hDA7A_0008);
            end
        end

        // Store and fetch to different words in the same cycle
        idle();
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b0011; m1_addr = 32'h200; m1_wdata = 32'hAABB_CCDD;
        m0_req = 1'b1; m0_addr = 32'h300;
        #1;
        chk("sf_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("sf_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("sf_wen", 32'(ram_wen), 32'h3);
        chk("sf_waddr", ram_w_addr, 32'h200);
        chk("sf_wdata", ram_w_data, 32'hAABB_CCDD);
        chk("sf_raddr", ram_r_addr, 32'h300);
        next_cycle();
        chk("sf_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("sf_m0_rdata", m0_rdata, 32'hDA7A_00C0);
        chk("sf_m1_rvalid", 32'(m1_rvalid), 32'd0);
        idle();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
        #1;
        chk("sf_load_gnt", 32'(m1_gnt), 32'd1);
        next_cycle();
        chk("sf_load_rvalid", 32'(m1_rvalid), 32'd1);
        chk("sf_load_rdata", m1_rdata, 32'hDA7A_CCDD);

        // Read-during-write hazard on the same word
        idle();
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF; m1_addr = 32'h204; m1_wdata = 32'h1234_5678;
        m0_req = 1'b1; m0_addr = 32'h206;
        #1;
        chk("hz_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("hz_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("hz_ren", 32'(ram_ren), 32'd0);
        next_cycle();
        chk("hz_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("hz_m1_rvalid", 32'(m1_rvalid), 32'd0);
        m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0;
        #1;
        chk("hz_retry_gnt", 32'(m0_gnt), 32'd1);
        chk("hz_retry_raddr", ram_r_addr, 32'h206);
        next_cycle();
        chk("hz_retry_rvalid", 32'(m0_rvalid), 32'd1);
        chk("hz_retry_rdata", m0_rdata, 32'h1234_5678);

        // Store with no byte enables
        idle();
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'h0; m1_addr = 32'h300; m1_wdata = 32'hFFFF_FFFF;
        #1;
        chk("be0_gnt", 32'(m1_gnt), 32'd1);
        chk("be0_wen", 32'(ram_wen), 32'd0);
        chk("be0_ren", 32'(ram_ren), 32'd0);
        next_cycle();
        chk("be0_rvalid", 32'(m1_rvalid), 32'd0);
        idle();
        m1_req = 1'b1; m1_addr = 32'h300;
        next_cycle();
        chk("be0_mem_rvalid", 32'(m1_rvalid), 32'd1);
        chk("be0_mem_rdata", m1_rdata, 32'hDA7A_00C0);

        // No requests: everything quiet
        idle();
        #1;
        chk("idle_ren", 32'(ram_ren), 32'd0);
        chk("idle_wen", 32'(ram_wen), 32'd0);
        chk("idle_raddr", ram_r_addr, 32'h0);
        chk("idle_waddr", ram_w_addr, 32'h0);
        chk("idle_wdata", ram_w_data, 32'h0);
        next_cycle();

        // Reset right after a granted load drops its response
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h104;
        #1;
        chk("rmr_gnt", 32'(m1_gnt), 32'd1);
        next_cycle();
        idle();
        rstn = 1'b0;
        #1;
        chk("rmr_rvalid_a", 32'(m1_rvalid), 32'd0);
        chk("rmr_rdata_a", m1_rdata, 32'h0);
        next_cycle();
        chk("rmr_rvalid_b", 32'(m1_rvalid), 32'd0);
        rstn = 1'b1;
        #1;
        chk("rmr_rvalid_c", 32'(m1_rvalid), 32'd0);
        chk("rmr_m0_rvalid", 32'(m0_rvalid), 32'd0);
        next_cycle();
        chk("rmr_rvalid_d", 32'(m1_rvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter in front of the byte-lane data/instruction RAM (separate write and read ports, 4-bit byte write enables, one-cycle registered read). It shares the single RAM read port between the instruction-fetch master (m0, read-only) and the load/store master (m1, read/write). It routes read data back to the owning master and blocks read-during-write to the same word. Sits between the core's IFU/LSU and the RAM wrapper.

## Interface
Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width (4 byte lanes)
- STARVE_MAX, 4, consecutive denied m0 cycles before m0 is forced to win the read port (1..15)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- m0_req  in  1  fetch read request
- m0_addr  in  AW  fetch byte address
- m0_gnt  out  1  fetch request accepted this cycle
- m0_rvalid  out  1  fetch read data valid
- m0_rdata  out  DW  fetch read data
- m1_req  in  1  load/store request
- m1_we  in  1  1 = store, 0 = load
- m1_be  in  4  store byte enables (ignored for loads)
- m1_addr  in  AW  load/store byte address
- m1_wdata  in  DW  store data
- m1_gnt  out  1  load/store request accepted this cycle
- m1_rvalid  out  1  load data valid (never asserted for stores)
- m1_rdata  out  DW  load data
- ram_wen  out  4  RAM byte write enables
- ram_w_addr  out  AW  RAM write byte address
- ram_w_data  out  DW  RAM write data
- ram_ren  out  1  RAM read enable
- ram_r_addr  out  AW  RAM read byte address
- ram_r_data  in  DW  RAM read data, valid the cycle after ram_ren

## Operation
- Request/grant: a master holds req, addr, we, be, and wdata stable until it samples gnt=1. A transfer occurs on a cycle with req & gnt.
- m1 store: always granted the same cycle. ram_wen = m1_be, ram_w_addr = m1_addr, ram_w_data = m1_wdata. No rvalid. be=0 is granted as a no-op (ram_wen=0).
- Word address for hazard compare is addr[AW-1:2]. Bits [1:0] are passed through unchanged; alignment is the requester's responsibility.
- Read port contention:
  - Default priority is m1 load over m0 fetch.
  - Starvation counter `starve` (4 bits) increments on each cycle with m0_req=1 and m0_gnt=0, and clears on an m0 grant or when m0_req=0.
  - When starve == STARVE_MAX and both masters want the read port, m0 wins and m1_gnt=0.
- Read-during-write hazard: if an m1 store is granted and m0_req targets the same word, m0_gnt=0 that cycle. The stall counts toward starve.
- m0 fetch and m1 store to different words are both granted in the same cycle.
- Response tag `rsp_own` is registered: NONE/M0/M1. It is set to the master whose read was granted and to NONE when no read is granted.
- Response routing:
  - m0_rvalid = (rsp_own==M0); m1_rvalid = (rsp_own==M1).
  - mX_rdata = ram_r_data when that master's rvalid is 1, else 0.
- Back-to-back reads are allowed every cycle; there is at most one outstanding read.

## Timing
- gnt, ram_ren, ram_r_addr, ram_wen, ram_w_addr, and ram_w_data are combinational from requests and `starve`.
- Read latency: grant at cycle t gives rvalid and rdata at t+1. Store is committed at the t edge.
- Reset (rstn=0 sampled at a clk edge):
  - starve=0, rsp_own=NONE.
  - m0_rvalid=m1_rvalid=0, rdata=0.
  - gnt, ram_ren, and ram_wen are forced to 0 while rstn=0.
  - A read granted in the cycle before reset has its response dropped.
- When no request is present: ram_ren=0, ram_wen=0, addresses and data are 0.
- starve saturates at STARVE_MAX and does not wrap.

## Test plan
- Reset: hold rstn=0 with both reqs high -> all gnt, rvalid, ram_wen, and ram_ren are 0. Release, then m0 reads 0x100 -> m0_gnt same cycle, m0_rvalid one cycle later with the preloaded word.
- Contention: m0 and m1 both continuously reading with STARVE_MAX=4 -> m1 granted 4 cycles, then m0 1 cycle, repeating. Every rvalid routes to the correct master and data matches the address.
- Store + fetch to different words (m1 store 0x200 be=4'b0011 wdata=0xAABBCCDD, m0 fetch 0x300) -> both granted the same cycle. A later read of 0x200 returns the old upper bytes with low half 0xCCDD.
- Hazard: m1 store to 0x204 while m0 fetches 0x206 -> m0_gnt=0. Next cycle m0 is granted and reads the new data.
- Store ack: m1 store with be=0 -> m1_gnt=1, ram_wen=0, no m1_rvalid, memory unchanged.
- Reset mid-read: m1 load granted, rstn=0 next edge -> no m1_rvalid pulse, rsp_own=NONE.
